// File: rtl/fcfs_dram_scheduler.sv
`default_nettype none
// fcfs_dram_scheduler: strict first-come-first-served DRAM command scheduler
// with per-bank open-page tracking and periodic all-bank refresh.
module fcfs_dram_scheduler #(
  parameter int T_RP   = 3,
  parameter int T_RCD  = 3,
  parameter int T_CL   = 4,
  parameter int T_RFC  = 8,
  parameter int T_REFI = 200
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ADDRESS_IN,
  input  logic [31:0] WRITE_DATA_IN,
  input  logic        R_W_IN,
  input  logic        EMPTY,
  output logic        POP,
  output logic [2:0]  CMD,
  output logic [2:0]  BANK,
  output logic [13:0] ROW,
  output logic [9:0]  COL,
  output logic [31:0] DQ_OUT,
  output logic        DQ_OE,
  input  logic [31:0] DQ_IN,
  output logic [31:0] RD_DATA,
  output logic        RD_VALID,
  output logic        BUSY
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT, S_ACCESS,
    S_RD_WAIT, S_PREA, S_PREA_WAIT, S_REF, S_REF_WAIT
  } state_t;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;
  localparam logic [2:0] CMD_REF  = 3'd6;
  localparam int RC_W = $clog2(T_REFI + 1);

  state_t            state, next_state;
  logic [7:0]        wait_cnt;
  logic [RC_W-1:0]   ref_cnt;
  logic              ref_pending;
  logic [7:0]        bank_open;
  logic [7:0][13:0]  open_row;
  logic [31:0]       rd_data_q;
  logic              rd_valid_q;

  logic [2:0]  head_bank;
  logic [13:0] head_row;
  logic [9:0]  head_col;
  logic        ref_wrap;
  logic        rd_done;
  logic        unused_addr_bits;

  assign head_col  = ADDRESS_IN[9:0];
  assign head_bank = ADDRESS_IN[12:10];
  assign head_row  = ADDRESS_IN[26:13];
  assign unused_addr_bits = ^ADDRESS_IN[31:27];

  assign ref_wrap = (ref_cnt == RC_W'(T_REFI - 1));
  assign rd_done  = (state == S_RD_WAIT) && (wait_cnt == 8'(T_CL - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      bank_open   <= '0;
      open_row    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state    <= next_state;
      // wait_cnt counts cycles spent in the current state
      wait_cnt <= (state != next_state) ? 8'd0 : wait_cnt + 8'd1;
      ref_cnt  <= ref_wrap ? '0 : ref_cnt + 1'b1;
      if (ref_wrap)
        ref_pending <= 1'b1;
      else if (state == S_REF_WAIT && next_state == S_IDLE)
        ref_pending <= 1'b0;
      case (state)
        S_PRE:  bank_open[head_bank] <= 1'b0;
        S_ACT: begin
          bank_open[head_bank] <= 1'b1;
          open_row[head_bank]  <= head_row;
        end
        S_PREA: bank_open <= '0;
        default: ;
      endcase
      rd_valid_q <= rd_done;
      if (rd_done) rd_data_q <= DQ_IN;
    end
  end

  always_comb begin
    next_state = state;
    CMD        = CMD_NOP;
    BANK       = '0;
    ROW        = '0;
    COL        = '0;
    POP        = 1'b0;
    DQ_OUT     = '0;
    DQ_OE      = 1'b0;
    case (state)
      S_IDLE: begin
        if (ref_pending)
          next_state = S_PREA;
        else if (!EMPTY) begin
          if (bank_open[head_bank] && open_row[head_bank] == head_row)
            next_state = S_ACCESS;
          else if (bank_open[head_bank])
            next_state = S_PRE;
          else
            next_state = S_ACT;
        end
      end
      S_PRE: begin
        CMD        = CMD_PRE;
        BANK       = head_bank;
        next_state = S_PRE_WAIT;
      end
      S_PRE_WAIT: if (wait_cnt == 8'(T_RP - 2)) next_state = S_ACT;
      S_ACT: begin
        CMD        = CMD_ACT;
        BANK       = head_bank;
        ROW        = head_row;
        next_state = S_ACT_WAIT;
      end
      S_ACT_WAIT: if (wait_cnt == 8'(T_RCD - 2)) next_state = S_ACCESS;
      S_ACCESS: begin
        BANK = head_bank;
        COL  = head_col;
        POP  = !EMPTY;
        if (R_W_IN) begin
          CMD        = CMD_WR;
          DQ_OUT     = WRITE_DATA_IN;
          DQ_OE      = 1'b1;
          next_state = S_IDLE;
        end else begin
          CMD        = CMD_RD;
          next_state = S_RD_WAIT;
        end
      end
      S_RD_WAIT:   if (rd_done) next_state = S_IDLE;
      S_PREA: begin
        CMD        = CMD_PREA;
        next_state = S_PREA_WAIT;
      end
      S_PREA_WAIT: if (wait_cnt == 8'(T_RP - 2)) next_state = S_REF;
      S_REF: begin
        CMD        = CMD_REF;
        next_state = S_REF_WAIT;
      end
      S_REF_WAIT:  if (wait_cnt == 8'(T_RFC - 2)) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  assign RD_DATA  = rd_data_q;
  assign RD_VALID = rd_valid_q;
  assign BUSY     = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fcfs_dram_scheduler.sv
`default_nettype none
// tb_fcfs_dram_scheduler: transaction-level timeline model of the scheduler,
// checked every cycle, plus directed scenarios pinned with literal cycle numbers.
`timescale 1ns/1ps
module tb_fcfs_dram_scheduler;
  localparam int T_RP = 3, T_RCD = 3, T_CL = 4, T_RFC = 8, T_REFI = 200;
  localparam int MAXC = 4096;
  localparam int NOP = 0, ACT = 1, RD = 2, WR = 3, PRE = 4, PREA = 5, REF = 6;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] ADDRESS_IN, WRITE_DATA_IN, DQ_IN;
  logic        R_W_IN, EMPTY;
  logic        POP, DQ_OE, RD_VALID, BUSY;
  logic [2:0]  CMD, BANK;
  logic [13:0] ROW;
  logic [9:0]  COL;
  logic [31:0] DQ_OUT, RD_DATA;

  fcfs_dram_scheduler #(.T_RP(T_RP), .T_RCD(T_RCD), .T_CL(T_CL), .T_RFC(T_RFC), .T_REFI(T_REFI)) dut (
    .CLK(CLK), .RESET(RESET), .ADDRESS_IN(ADDRESS_IN), .WRITE_DATA_IN(WRITE_DATA_IN),
    .R_W_IN(R_W_IN), .EMPTY(EMPTY), .POP(POP), .CMD(CMD), .BANK(BANK), .ROW(ROW),
    .COL(COL), .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE), .DQ_IN(DQ_IN), .RD_DATA(RD_DATA),
    .RD_VALID(RD_VALID), .BUSY(BUSY));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
  } req_t;
  req_t fifo[$];

  int checks = 0, errors = 0;
  int cyc, idle_at, next_ref;
  bit mopen[8];
  int mrow[8];
  int e_cmd[MAXC], e_bank[MAXC], e_row[MAXC], e_col[MAXC], e_rsrc[MAXC];
  bit e_pop[MAXC], e_oe[MAXC], e_rv[MAXC];
  logic [31:0] e_dout[MAXC], dq_hist[MAXC];
  int log_cmd[MAXC];
  bit log_rv[MAXC], log_pop[MAXC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; idle_at = 0; next_ref = T_REFI;
    for (int b = 0; b < 8; b++) begin mopen[b] = 0; mrow[b] = 0; end
    for (int i = 0; i < MAXC; i++) begin
      e_cmd[i] = NOP; e_bank[i] = 0; e_row[i] = 0; e_col[i] = 0; e_rsrc[i] = 0;
      e_pop[i] = 0; e_oe[i] = 0; e_rv[i] = 0; e_dout[i] = '0;
      log_cmd[i] = NOP; log_rv[i] = 0; log_pop[i] = 0;
    end
  endtask

  task automatic put(input int c, input int cmd, input int b, input int r, input int col);
    e_cmd[c] = cmd; e_bank[c] = b; e_row[c] = r; e_col[c] = col;
  endtask

  // Plan the whole timeline of whatever the scheduler starts from this idle cycle.
  task automatic decide();
    req_t h;
    int b, r, a;
    if (cyc >= next_ref) begin
      put(cyc + 1, PREA, 0, 0, 0);
      put(cyc + 1 + T_RP, REF, 0, 0, 0);
      idle_at = cyc + 1 + T_RP + T_RFC;
      for (int k = 0; k < 8; k++) mopen[k] = 0;
      next_ref += T_REFI;
    end else if (fifo.size() != 0) begin
      h = fifo[0];
      b = int'(h.addr[12:10]);
      r = int'(h.addr[26:13]);
      a = cyc + 1;
      if (!(mopen[b] && mrow[b] == r)) begin
        if (mopen[b]) begin put(a, PRE, b, 0, 0); a += T_RP; end
        put(a, ACT, b, r, 0); a += T_RCD;
      end
      mopen[b] = 1; mrow[b] = r;
      put(a, h.rw ? WR : RD, b, 0, int'(h.addr[9:0]));
      e_pop[a] = 1;
      if (h.rw) begin
        e_oe[a] = 1; e_dout[a] = h.data; idle_at = a + 1;
      end else begin
        e_rv[a + T_CL + 1] = 1; e_rsrc[a + T_CL + 1] = a + T_CL; idle_at = a + T_CL + 1;
      end
    end else begin
      idle_at = cyc + 1;
    end
  endtask

  task automatic compare(input bit exp_busy);
    chk("cmd", 32'(CMD), e_cmd[cyc]);
    chk("bank", 32'(BANK), e_bank[cyc]);
    chk("row", 32'(ROW), e_row[cyc]);
    chk("col", 32'(COL), e_col[cyc]);
    chk("pop", 32'(POP), 32'(e_pop[cyc]));
    chk("dq_oe", 32'(DQ_OE), 32'(e_oe[cyc]));
    chk("dq_out", DQ_OUT, e_dout[cyc]);
    chk("rd_valid", 32'(RD_VALID), 32'(e_rv[cyc]));
    chk("busy", 32'(BUSY), 32'(exp_busy));
    if (e_rv[cyc]) chk("rd_data", RD_DATA, dq_hist[e_rsrc[cyc]]);
  endtask

  // Entered at posedge+1 of cycle cyc; leaves at posedge+1 of cycle cyc+1.
  task automatic cycle_body();
    bit eb, popped;
    if (cyc >= MAXC - 32) begin
      $display("FAIL cycle_budget cycle %0d: got overrun expected below %0d", cyc, MAXC - 32);
      $fatal(1);
    end
    EMPTY = (fifo.size() == 0);
    if (!EMPTY) begin
      ADDRESS_IN = fifo[0].addr; WRITE_DATA_IN = fifo[0].data; R_W_IN = fifo[0].rw;
    end else begin
      ADDRESS_IN = $urandom; WRITE_DATA_IN = $urandom; R_W_IN = 1'($urandom);
    end
    DQ_IN = $urandom;
    dq_hist[cyc] = DQ_IN;
    eb = (cyc != idle_at);
    if (cyc == idle_at) decide();
    #2;
    compare(eb);
    log_cmd[cyc] = int'(CMD); log_rv[cyc] = RD_VALID; log_pop[cyc] = POP;
    popped = POP;
    @(posedge CLK);
    if (popped && fifo.size() != 0) void'(fifo.pop_front());
    #1;
    cyc++;
  endtask

  task automatic push(input logic [31:0] a, input logic rw, input logic [31:0] d);
    req_t r;
    r.addr = a; r.rw = rw; r.data = d;
    fifo.push_back(r);
  endtask

  task automatic reset_checks();
    chk("rst_cmd", 32'(CMD), NOP);
    chk("rst_pop", 32'(POP), 0);
    chk("rst_dq_oe", 32'(DQ_OE), 0);
    chk("rst_dq_out", DQ_OUT, 0);
    chk("rst_rd_valid", 32'(RD_VALID), 0);
    chk("rst_rd_data", RD_DATA, 0);
    chk("rst_busy", 32'(BUSY), 0);
  endtask

  initial begin
    int n;
    EMPTY = 1'b1; ADDRESS_IN = '0; WRITE_DATA_IN = '0; R_W_IN = 1'b0; DQ_IN = '0;
    @(posedge CLK); #1;
    reset_checks();
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();

    // Directed: miss read, hit writes, conflict, refresh behind an in-flight read.
    // 0x2404 decodes to bank 1, col 4, and row 1 because bit 13 is set.
    push(32'h0000_2404, 1'b0, 32'h0);
    while (cyc < 230) begin
      if (cyc == 9) begin
        push(32'h0000_2408, 1'b1, 32'hA5A5_0001);
        push(32'h0000_240C, 1'b1, 32'hA5A5_0002);
      end
      if (cyc == 20)  push(32'h0000_6400, 1'b1, 32'h1234_5678);
      if (cyc == 195) push(32'h0000_0800, 1'b0, 32'h0);
      if (cyc == 210) push(32'h0000_6400, 1'b0, 32'h0);
      cycle_body();
    end
    chk("a_act_t1", log_cmd[1], ACT);
    chk("a_rd_t4", log_cmd[4], RD);
    chk("a_valid_t9", 32'(log_rv[9]), 1);
    chk("a_novalid_t8", 32'(log_rv[8]), 0);
    n = 0;
    for (int i = 0; i <= 8; i++) n += int'(log_pop[i]);
    chk("a_pop_once", n, 1);
    chk("a_pop_t4", 32'(log_pop[4]), 1);
    chk("b_wr1_t10", log_cmd[10], WR);
    chk("b_gap_t11", log_cmd[11], NOP);
    chk("b_wr2_t12", log_cmd[12], WR);
    chk("c_pre_t21", log_cmd[21], PRE);
    chk("c_act_t24", log_cmd[24], ACT);
    chk("c_wr_t27", log_cmd[27], WR);
    chk("r_valid_t204", 32'(log_rv[204]), 1);
    chk("r_prea_t205", log_cmd[205], PREA);
    chk("r_ref_t208", log_cmd[208], REF);
    chk("r_act_t217", log_cmd[217], ACT);

    // Randomized traffic over few rows to mix hits, conflicts and misses.
    while (cyc < 3200) begin
      if (fifo.size() < 3 && $urandom_range(0, 3) == 0)
        push({5'($urandom), 14'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 10'($urandom)},
             1'($urandom), $urandom);
      cycle_body();
    end

    // Reset pulsed during ACT_WAIT: nothing popped, request replayed as a miss.
    RESET = 1'b1;
    fifo.delete();
    #1 reset_checks();
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
    push(32'h0000_0C10, 1'b1, 32'hDEAD_BEEF);
    cycle_body();
    cycle_body();
    RESET = 1'b1;
    #1 reset_checks();
    chk("d_head_kept", fifo.size(), 1);
    @(posedge CLK); @(posedge CLK); #1;
    reset_checks();
    RESET = 1'b0;
    model_reset();
    while (cyc < 10) cycle_body();
    chk("d_act_t1", log_cmd[1], ACT);
    chk("d_wr_t4", log_cmd[4], WR);
    chk("d_popped", fifo.size(), 0);

    // Empty FIFO for 500 cycles: only refresh sequences.
    RESET = 1'b1;
    #1 reset_checks();
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
    while (cyc < 500) cycle_body();
    n = 0;
    for (int i = 0; i < 500; i++) n += (log_cmd[i] == PREA) ? 1 : 0;
    chk("e_prea_count", n, 2);
    n = 0;
    for (int i = 0; i < 500; i++) n += (log_cmd[i] == REF) ? 1 : 0;
    chk("e_ref_count", n, 2);
    n = 0;
    for (int i = 0; i < 500; i++) n += int'(log_pop[i]);
    chk("e_no_pop", n, 0);
    chk("e_prea_t201", log_cmd[201], PREA);
    chk("e_prea_t401", log_cmd[401], PREA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
